uart_rx_param: RTL

Parametrised UART receiver. It is the next generation of the fixed 8N1 receiver and replaces it wherever configurable framing is needed. It adds selectable data width, parity and stop bits, an rx synchroniser, start-bit glitch rejection and 3-sample majority voting. It reports parity, framing, overrun and break per frame on a valid/ready output toward the host-side FIFO or bus bridge.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Host-side word port of the parametrised UART receiver: valid/ready word plus per-frame status.
// master = receiver, slave = host FIFO or bus bridge.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 ready;
    logic                 data_val;
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 break_det;

    modport master (
        input  ready,
        output data_val, data, parity_err, frame_err, overrun, break_det
    );

    modport slave (
        output ready,
        input  data_val, data, parity_err, frame_err, overrun, break_det
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop rx sync, glitch-rejecting start, 3-sample majority vote per bit.
// Latency: word valid 2 cycles after the last stop bit's mid-bit decision.
// Backpressure: data_val holds until ready; a frame completing while held is dropped with an overrun pulse.
module uart_rx_param #(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 1000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            rx,
    uart_rx_param_if.master host
);
    localparam int CPB  = CLK_RATE / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [3:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr, perr_nxt, ferr, ferr_nxt, pbit, pbit_nxt, done, done_nxt;
    logic                 smp0, smp1, vote, at_dec, at_end, brk;

    assign vote   = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign at_dec = (bit_cnt == CW'(HALF + 1));
    assign at_end = (bit_cnt == CW'(CPB - 1));
    assign brk    = done && ferr && (shreg == '0) && !pbit;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        perr_nxt    = perr;
        ferr_nxt    = ferr;
        pbit_nxt    = pbit;
        done_nxt    = 1'b0;
        if (state inside {S_START, S_DATA, S_PARITY, S_STOP})
            bit_cnt_nxt = at_end ? '0 : bit_cnt + CW'(1);
        case (state)
            S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt   = S_START;
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    perr_nxt    = 1'b0;
                    ferr_nxt    = 1'b0;
                    pbit_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (at_dec && vote)
                    state_nxt = S_IDLE;
                else if (at_end)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (at_dec) shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                        bit_idx_nxt = '0;
                        state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_dec) begin
                    pbit_nxt = vote;
                    perr_nxt = (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                end
                if (at_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Complete at the last stop bit's decision point so back-to-back starts are not missed.
                if (at_dec) begin
                    ferr_nxt = ferr | ~vote;
                    if (bit_idx == 4'(STOP_BITS - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = (ferr | ~vote) ? S_WAIT_IDLE : S_IDLE;
                    end
                end
                if (at_end) bit_idx_nxt = bit_idx + 4'd1;
            end
            default: state_nxt = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= S_WAIT_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            pbit    <= 1'b0;
            done    <= 1'b0;
            smp0    <= 1'b1;
            smp1    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            perr    <= perr_nxt;
            ferr    <= ferr_nxt;
            pbit    <= pbit_nxt;
            done    <= done_nxt;
            if (bit_cnt == CW'(HALF - 1)) smp0 <= rx_s;
            if (bit_cnt == CW'(HALF))     smp1 <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            host.data_val   <= 1'b0;
            host.data       <= '0;
            host.parity_err <= 1'b0;
            host.frame_err  <= 1'b0;
            host.overrun    <= 1'b0;
            host.break_det  <= 1'b0;
        end else begin
            host.overrun   <= 1'b0;
            host.break_det <= brk;
            if (host.data_val && host.ready) begin
                host.data_val   <= 1'b0;
                host.parity_err <= 1'b0;
                host.frame_err  <= 1'b0;
            end
            if (done) begin
                if (!host.data_val || host.ready) begin
                    host.data_val   <= 1'b1;
                    host.data       <= shreg;
                    host.parity_err <= perr;
                    host.frame_err  <= ferr;
                end else begin
                    host.overrun <= 1'b1;
                end
            end
        end
    end
endmodule
